// File: rtl/decoder_seq_pkg.sv
// rtl/decoder_seq_pkg.sv - shared state encoding and decode/parity helpers for decoder_seq
package decoder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEVEL = 2'd1,
        PULSE = 2'd2
    } state_t;

    // Helpers work at the widest supported select; callers cast down to their own width.
    localparam int MAX_SEL_W = 8;

    function automatic logic [2**MAX_SEL_W-1:0] onehot(input logic [MAX_SEL_W-1:0] code);
        logic [2**MAX_SEL_W-1:0] r;
        r       = '0;
        r[code] = 1'b1;
        return r;
    endfunction

    function automatic logic even_par(input logic [MAX_SEL_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/decoder_seq_timer.sv
// rtl/decoder_seq_timer.sv - loadable down-counter that times the pulse-mode hold
module decoder_seq_timer #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              tick,
    output logic              zero
);

    logic [HOLD_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - registered N-to-2^N one-hot decoder with level and timed-pulse modes
// Optional select parity check: DECODER_SEQ_PARITY_EN
module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W       = 3,
    parameter int HOLD_W      = 4,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    input  logic                pulse_mode,
    input  logic [HOLD_W-1:0]   hold,
`ifdef DECODER_SEQ_PARITY_EN
    input  logic                sel_par,
    output logic                par_err,
`endif
    output logic [2**SEL_W-1:0] dout,
    output logic                dout_valid,
    output logic                done
);

    localparam int OUT_W = 2**SEL_W;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   line_q, line_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               accept;
    logic               par_ok;
    logic               tmr_load, tmr_tick, tmr_zero;

    assign in_ready = (state_q != PULSE);
    assign accept   = in_valid && in_ready;

`ifdef DECODER_SEQ_PARITY_EN
    assign par_ok = (sel_par == even_par(MAX_SEL_W'(sel)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= accept && !par_ok;
        end
    end
`else
    assign par_ok = 1'b1;
`endif

    decoder_seq_timer #(
        .HOLD_W (HOLD_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (hold),
        .tick     (tmr_tick),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_tick = 1'b0;
        case (state_q)
            PULSE: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                    line_d  = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    tmr_tick = 1'b1;
                end
            end
            default: begin
                // A new code overwrites the whole bus in one edge, so no two-hot cycle exists.
                if (accept && par_ok) begin
                    if (!en) begin
                        state_d = IDLE;
                        line_d  = '0;
                        valid_d = 1'b0;
                    end else begin
                        state_d  = pulse_mode ? PULSE : LEVEL;
                        line_d   = OUT_W'(onehot(MAX_SEL_W'(sel)));
                        valid_d  = 1'b1;
                        tmr_load = pulse_mode;
                    end
                end
            end
        endcase
    end

    assign dout       = ACTIVE_HIGH ? line_q : ~line_q;
    assign dout_valid = valid_q;
    assign done       = done_q;

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. Successor to the 3-to-8 combinational decoder.
- Accepts select codes through a valid/ready handshake and drives a one-hot output bus.
- Two output modes: level (held) or timed pulse with a programmable hold count.
- Sits between control FSMs and per-channel enable/strobe lines.

Parameters:
- SEL_W, 3, select width N; output width is 2^SEL_W.
- HOLD_W, 4, width of the pulse hold counter.
- ACTIVE_HIGH, 1, 1 means the asserted line is 1 and idle lines are 0; 0 inverts the whole output bus.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  block can accept a command this cycle.
- sel  in  SEL_W  code to decode.
- en  in  1  when 0, an accepted command clears the outputs instead of asserting a line.
- pulse_mode  in  1  sampled on accept; 1 = pulse, 0 = level.
- hold  in  HOLD_W  sampled on accept; pulse length is hold+1 cycles.
- dout  out  2^SEL_W  decoded bus.
- dout_valid  out  1  high while any line is asserted.
- done  out  1  one-cycle strobe when a pulse ends.

Behaviour:
- Reset (async, immediate):
  - dout = all idle (0 if ACTIVE_HIGH, all-ones otherwise).
  - dout_valid = 0, done = 0, in_ready = 1, state IDLE, counter = 0.
- Accept occurs when in_valid && in_ready at a rising edge.
- Latency: dout updates on the accepting edge, so it is visible the cycle after the request. No combinational path from sel to dout.
- Decode: line[sel] asserted, all other lines idle. Exactly one line is asserted when dout_valid = 1.
- States:
  - IDLE: in_ready = 1.
    - Accept with en = 0: dout idle, dout_valid = 0, stay IDLE.
    - Accept with en = 1, pulse_mode = 0: go to LEVEL.
    - Accept with en = 1, pulse_mode = 1: go to PULSE, counter loaded with hold.
  - LEVEL: in_ready = 1. Output is held until the next accept, which re-decodes (goes to LEVEL, PULSE or IDLE as above). A new sel replaces the old line in a single edge; there is never a two-hot cycle.
  - PULSE: in_ready = 0.
    - Counter decrements each cycle.
    - The edge where counter == 0: dout goes idle, dout_valid = 0, done = 1 for one cycle, return to IDLE.
    - hold = 0 gives a 1-cycle pulse. hold = max gives 2^HOLD_W cycles.
- While in_ready = 0, sel, en, pulse_mode and hold are ignored; in_valid may stay high and the command is accepted on the first cycle after done.
- done and a new accept never share an edge, because in_ready is 0 on the done edge.
- Reset asserted mid-pulse: outputs go idle at once and done is not issued.

Optional Feature:
- Macro DECODER_SEQ_PARITY_EN.
- When defined:
  - Adds input sel_par (1 bit, even parity over sel) and output par_err (1 bit).
  - An accept with a parity mismatch does not change dout or state and raises par_err for one cycle.
  - par_err resets to 0.
- When undefined: neither port exists and every accept is decoded.

Decomposition:
- Package decoder_seq_pkg:
  - State enum: IDLE, LEVEL, PULSE.
  - Function onehot(sel) returning a 2^SEL_W-bit vector.
  - Even-parity function.
- Sub-module decoder_seq_timer: loadable down-counter with load, tick and zero outputs, parametrised by HOLD_W.
- The decode logic stays inline in decoder_seq.

Test Plan:
- Reset, then level mode sel = 5, en = 1, pulse_mode = 0 -> next cycle dout = 8'b0010_0000, dout_valid = 1, held 10 cycles unchanged.
- Level mode sel = 5 then back-to-back sel = 2 -> dout goes 0010_0000 to 0000_0100 in one edge with no two-hot cycle; then a command with en = 0 -> dout = 0, dout_valid = 0.
- Pulse mode sel = 7, hold = 3 -> dout = 1000_0000 for exactly 4 cycles, done high on the 4th edge, in_ready low for 4 cycles. A queued in_valid with sel = 1 is accepted the cycle after done.
- Pulse mode hold = 0 -> 1-cycle pulse; hold = 15 -> 16-cycle pulse.
- rst asserted asynchronously mid-pulse (between clock edges) -> dout = 0 immediately, no done, in_ready = 1 after release.
- With DECODER_SEQ_PARITY_EN, sel = 3 and sel_par = 1 (bad) -> par_err pulses 1 cycle and dout unchanged; sel_par = 0 -> dout = 0000_1000.
- Sweep: SEL_W = 4 and ACTIVE_HIGH = 0 -> all 16 codes give an active-low one-hot bus.
